// File: rtl/fifostack_arbiter_if.sv
// Handshake bundle between two producers, one consumer, the shared fifostack and the arbiter.
// The arbiter takes the slave modport; the surrounding logic (or bench) takes master.
interface fifostack_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             a_req;
    logic [WIDTH-1:0] a_data;
    logic             a_gnt;
    logic             b_req;
    logic [WIDTH-1:0] b_data;
    logic             b_gnt;
    logic             rd_req;
    logic             rd_gnt;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             fifo_enqueue;
    logic             fifo_dequeue;
    logic [WIDTH-1:0] fifo_data_in;
    logic             fifo_reset_n;
    logic             fifo_empty;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_data_out;
    logic [2:0]       occupancy;
    logic             err;

    modport master (
        output flush, a_req, a_data, b_req, b_data, rd_req,
               fifo_empty, fifo_full, fifo_data_out,
        input  a_gnt, b_gnt, rd_gnt, rd_valid, rd_data,
               fifo_enqueue, fifo_dequeue, fifo_data_in, fifo_reset_n,
               occupancy, err
    );

    modport slave (
        input  flush, a_req, a_data, b_req, b_data, rd_req,
               fifo_empty, fifo_full, fifo_data_out,
        output a_gnt, b_gnt, rd_gnt, rd_valid, rd_data,
               fifo_enqueue, fifo_dequeue, fifo_data_in, fifo_reset_n,
               occupancy, err
    );
endinterface

// File: rtl/fifostack_arbiter.sv
// Arbitrates two producers and one consumer onto a single fifostack, issuing at most
// one fifostack command per cycle, tracking occupancy and sequencing the fifostack flush.
//
// state | meaning
// FLUSH | fifo_reset_n held low this cycle; occupancy and err cleared at its end
// IDLE  | no fifostack command
// PUSH  | enqueue of the round-robin winner's word
// POP   | dequeue; popped word appears on rd_data next cycle with rd_valid
module fifostack_arbiter #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 7,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clock,
    input logic               reset,
    fifostack_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {FLUSH, IDLE, PUSH, POP} state_t;

    state_t           state;
    logic             a_gnt_q;
    logic             b_gnt_q;
    logic             rd_gnt_q;
    logic             rd_valid_q;
    logic             enq_q;
    logic             deq_q;
    logic [WIDTH-1:0] data_in_q;
    logic             fifo_rstn_q;
    logic [2:0]       occ_q;
    logic             err_q;
    logic             rr_b;
    logic [SW-1:0]    starve;

    logic [2:0]       occ_nxt;
    logic             a_el;
    logic             b_el;
    logic             push_el;
    logic             pop_el;
    logic             push_win;
    logic             pick_b;
    logic             flag_mismatch;

    // Occupancy as it will stand once the command in flight this cycle retires.
    always_comb begin
        occ_nxt = occ_q;
        case (state)
            FLUSH:   occ_nxt = 3'd0;
            PUSH:    occ_nxt = occ_q + 3'd1;
            POP:     occ_nxt = occ_q - 3'd1;
            default: occ_nxt = occ_q;
        endcase
    end

    // A requester granted this cycle still shows its old request at the edge; skip it once.
    assign a_el     = bus.a_req & ~a_gnt_q;
    assign b_el     = bus.b_req & ~b_gnt_q;
    assign push_el  = (a_el | b_el) && (occ_nxt < 3'(DEPTH));
    assign pop_el   = bus.rd_req && !rd_gnt_q && (occ_nxt != 3'd0);
    assign push_win = push_el && (!pop_el || (starve >= SW'(STARVE_LIMIT)));
    assign pick_b   = b_el && (!a_el || rr_b);

    assign flag_mismatch = ((occ_q == 3'd0) != bus.fifo_empty) ||
                           ((occ_q == 3'(DEPTH)) != bus.fifo_full);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= FLUSH;
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            rd_gnt_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            enq_q       <= 1'b0;
            deq_q       <= 1'b0;
            data_in_q   <= '0;
            fifo_rstn_q <= 1'b0;
            occ_q       <= 3'd0;
            err_q       <= 1'b0;
            rr_b        <= 1'b0;
            starve      <= '0;
        end else begin
            a_gnt_q     <= 1'b0;
            b_gnt_q     <= 1'b0;
            rd_gnt_q    <= 1'b0;
            enq_q       <= 1'b0;
            deq_q       <= 1'b0;
            fifo_rstn_q <= 1'b1;
            rd_valid_q  <= (state == POP);
            occ_q       <= occ_nxt;
            // Flags are stale during the flush cycle itself, so it is not cross-checked.
            err_q       <= (state == FLUSH) ? 1'b0 : (err_q | flag_mismatch);

            if (bus.flush) begin
                state       <= FLUSH;
                fifo_rstn_q <= 1'b0;
                starve      <= '0;
            end else if (push_win) begin
                state  <= PUSH;
                enq_q  <= 1'b1;
                starve <= '0;
                rr_b   <= ~rr_b;
                if (pick_b) begin
                    b_gnt_q   <= 1'b1;
                    data_in_q <= bus.b_data;
                end else begin
                    a_gnt_q   <= 1'b1;
                    data_in_q <= bus.a_data;
                end
            end else if (pop_el) begin
                state    <= POP;
                deq_q    <= 1'b1;
                rd_gnt_q <= 1'b1;
                // Pop only beats an eligible push while starve is below the limit.
                starve   <= push_el ? starve + SW'(1) : '0;
            end else begin
                state  <= IDLE;
                starve <= '0;
            end
        end
    end

    assign bus.a_gnt        = a_gnt_q;
    assign bus.b_gnt        = b_gnt_q;
    assign bus.rd_gnt       = rd_gnt_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = bus.fifo_data_out;
    assign bus.fifo_enqueue = enq_q;
    assign bus.fifo_dequeue = deq_q;
    assign bus.fifo_data_in = data_in_q;
    assign bus.fifo_reset_n = fifo_rstn_q;
    assign bus.occupancy    = occ_q;
    assign bus.err          = err_q;
endmodule

// File: tb/tb_fifostack_arbiter.sv
// Directed bench for fifostack_arbiter with a behavioural 7-slot fifostack attached.
module tb_fifostack_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_vec  = 0;
    int   n_miss = 0;

    fifostack_arbiter_if #(.WIDTH(32)) bus();

    fifostack_arbiter #(.WIDTH(32), .DEPTH(7), .STARVE_LIMIT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Behavioural fifostack: synchronous active-low reset, 7 usable slots.
    logic [31:0] mq[$];
    logic [31:0] m_out    = '0;
    int          m_cnt    = 0;
    logic        force_ne = 1'b0;

    always @(posedge clock) begin
        if (!bus.fifo_reset_n) begin
            mq.delete();
        end else if (bus.fifo_enqueue) begin
            mq.push_back(bus.fifo_data_in);
        end else if (bus.fifo_dequeue && mq.size() > 0) begin
            m_out <= mq.pop_front();
        end
        m_cnt <= mq.size();
    end

    assign bus.fifo_empty    = (m_cnt == 0) && !force_ne;
    assign bus.fifo_full     = (m_cnt == 7);
    assign bus.fifo_data_out = m_out;

    typedef struct packed {
        logic        a, b, rd, fl;
        logic        ea, eb, er, ev, ern;
        logic [2:0]  eocc;
        logic [31:0] edata;
    } vec_t;

    vec_t tbl [17];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        tick();
    endtask

    function automatic logic [8:0] snap();
        return {bus.a_gnt, bus.b_gnt, bus.rd_gnt, bus.rd_valid, bus.fifo_reset_n,
                bus.occupancy, bus.err};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int ng;
        int won;
        bit got;

        bus.flush  = 1'b0;
        bus.a_req  = 1'b0;
        bus.b_req  = 1'b0;
        bus.rd_req = 1'b0;
        bus.a_data = 32'h11;
        bus.b_data = 32'h22;

        //            a  b  rd fl  ea eb er ev ern occ   data
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1, 3'd0, 32'h0};
        tbl[1]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1, 3'd1, 32'h0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1, 3'd0, 32'h11};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1, 3'd0, 32'h0};
        tbl[4]  = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1, 3'd1, 32'h0};
        tbl[5]  = '{1'b1,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b1, 3'd2, 32'h0};
        tbl[6]  = '{1'b1,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1, 3'd3, 32'h0};
        tbl[7]  = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b1, 3'd2, 32'h22};
        tbl[8]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1, 3'd3, 32'h0};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1, 3'd2, 32'h11};
        tbl[10] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1, 3'd2, 32'h0};
        tbl[11] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1, 3'd1, 32'h22};
        tbl[12] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0,1'b1, 3'd1, 32'h0};
        tbl[13] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b1, 3'd0, 32'h11};
        tbl[14] = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b1, 3'd0, 32'h0};
        tbl[15] = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 3'd0, 32'h0};
        tbl[16] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1, 3'd0, 32'h0};

        // Reset, release, single flush cycle, then quiet.
        tick();
        tick();
        chk("in_reset", {bus.a_gnt, bus.b_gnt, bus.rd_gnt, bus.fifo_enqueue,
                         bus.fifo_dequeue, bus.fifo_reset_n, bus.occupancy, bus.err},
            {5'b00000, 1'b0, 3'd0, 1'b0});
        reset = 1'b1;
        chk("flush_after_release", bus.fifo_reset_n, 1'b0);
        tick();
        chk("idle_after_flush", snap(), {5'b00001, 3'd0, 1'b0});
        tick();
        tick();
        chk("idle_quiet", {snap(), bus.fifo_enqueue, bus.fifo_dequeue},
            {5'b00001, 3'd0, 1'b0, 2'b00});

        for (int i = 0; i < 17; i++) begin
            bus.a_req  = tbl[i].a;
            bus.b_req  = tbl[i].b;
            bus.rd_req = tbl[i].rd;
            bus.flush  = tbl[i].fl;
            tick();
            chk($sformatf("vec%0d", i), snap(),
                {tbl[i].ea, tbl[i].eb, tbl[i].er, tbl[i].ev, tbl[i].ern, tbl[i].eocc, 1'b0});
            if (tbl[i].ev)
                chk($sformatf("vec%0d_data", i), bus.rd_data, tbl[i].edata);
        end
        bus.a_req = 1'b0;
        bus.flush = 1'b0;
        bus.rd_req = 1'b0;

        // Fill to DEPTH, then an eighth A request must stall until a pop.
        do_flush();
        bus.a_req = 1'b1;
        bus.b_req = 1'b1;
        ng = 0;
        for (int i = 0; i < 20 && ng < 7; i++) begin
            tick();
            if (bus.a_gnt || bus.b_gnt) ng++;
        end
        chk("fill_grants", ng, 7);
        bus.b_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("full_stall%0d", i), bus.a_gnt, 1'b0);
        end
        chk("full_flags", {bus.occupancy, bus.fifo_full, bus.err}, {3'd7, 1'b1, 1'b0});
        bus.rd_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            tick();
            got = bus.rd_gnt;
        end
        bus.rd_req = 1'b0;
        chk("full_pop_gnt", got, 1'b1);
        tick();
        chk("push_after_pop", bus.a_gnt, 1'b1);
        bus.a_req = 1'b0;
        tick();
        chk("refilled", {bus.occupancy, bus.fifo_full, bus.err}, {3'd7, 1'b1, 1'b0});

        // Contention: occupancy 3, pop and push held together; push must not starve.
        do_flush();
        bus.a_req = 1'b1;
        ng = 0;
        for (int i = 0; i < 20 && ng < 3; i++) begin
            tick();
            if (bus.a_gnt) ng++;
        end
        bus.a_req = 1'b0;
        tick();
        chk("starve_setup_occ", bus.occupancy, 3'd3);
        bus.a_req  = 1'b1;
        bus.rd_req = 1'b1;
        won = 0;
        for (int i = 1; i <= 5 && won == 0; i++) begin
            tick();
            if (bus.a_gnt) won = i;
        end
        bus.a_req  = 1'b0;
        bus.rd_req = 1'b0;
        chk("push_within_5", (won != 0) && (won <= 5), 1'b1);
        chk("no_err_contention", bus.err, 1'b0);

        // Flush with five words held, then a forced flag disagreement.
        do_flush();
        bus.a_req = 1'b1;
        bus.b_req = 1'b1;
        ng = 0;
        for (int i = 0; i < 20 && ng < 5; i++) begin
            tick();
            if (bus.a_gnt || bus.b_gnt) ng++;
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick();
        chk("occ5", bus.occupancy, 3'd5);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_cycle", {bus.fifo_reset_n, bus.a_gnt, bus.b_gnt, bus.rd_gnt}, 4'b0000);
        tick();
        chk("post_flush", {bus.occupancy, bus.fifo_empty, bus.err}, {3'd0, 1'b1, 1'b0});
        force_ne = 1'b1;
        tick();
        chk("err_set", bus.err, 1'b1);
        force_ne = 1'b0;
        tick();
        tick();
        chk("err_sticky", bus.err, 1'b1);
        do_flush();
        chk("err_cleared", bus.err, 1'b0);

        // Async reset during a push: outputs drop at once, flush follows release.
        bus.a_req = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            tick();
            got = bus.a_gnt;
        end
        chk("pre_reset_gnt", got, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", {bus.a_gnt, bus.fifo_enqueue, bus.fifo_reset_n, bus.occupancy},
            {3'b000, 3'd0});
        bus.a_req = 1'b0;
        tick();
        reset = 1'b1;
        chk("reset_release_flush", bus.fifo_reset_n, 1'b0);
        tick();
        chk("reset_recovered", snap(), {5'b00001, 3'd0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
